// File: rtl/vga_capture.sv
// VGA receive-side capture: rebuilds raster position from BLANK_n/VS and streams
// pixels to a framebuffer with per-frame status. Optional checksum via VGA_CAPTURE_SUM_EN.
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              iBLANK_n,
    input  logic              iHS,
    input  logic              iVS,
    input  logic [7:0]        iR,
    input  logic [7:0]        iG,
    input  logic [7:0]        iB,
    output logic              oWR_EN,
    output logic [ADDR_W-1:0] oWR_ADDR,
    output logic [23:0]       oWR_DATA,
    output logic              oFRAME_DONE,
    output logic [ADDR_W-1:0] oFRAME_PIX,
    output logic              oFRAME_ERR,
    output logic [31:0]       oFRAME_SUM,
    output logic              oLOCKED
);

    localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int PW    = ADDR_W + 1;
    localparam logic [PW-1:0]    TOTAL    = PW'(H_ACTIVE * V_ACTIVE);
    localparam logic [PW-1:0]    H_STEP   = PW'(H_ACTIVE);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);

    typedef enum logic [1:0] {SEEK, VSYNC, ACTIVE} state_t;

    state_t state, state_nxt;

    logic vs_d, blank_d;
    logic vs_fall, vs_rise, blank_fall;
    logic pix_valid, wr_ok, frame_end, frame_start, line_fix;
    logic frame_err_c;

    logic [COL_W-1:0] col;
    logic [PW-1:0]    row_base;
    logic [PW-1:0]    addr;
    logic [PW-1:0]    pix_cnt;
    logic [PW-1:0]    next_base;
    logic [PW-1:0]    realign_base;
    logic             line_err;
    logic             overflow;

    // Horizontal sync carries no information we need; BLANK_n marks the lines.
    logic unused_hs;
    assign unused_hs = iHS;

    assign vs_fall    = vs_d & ~iVS;
    assign vs_rise    = ~vs_d & iVS;
    assign blank_fall = blank_d & ~iBLANK_n;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vs_d    <= 1'b0;
            blank_d <= 1'b0;
        end else begin
            vs_d    <= iVS;
            blank_d <= iBLANK_n;
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) state <= SEEK;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEEK:    if (vs_fall) state_nxt = VSYNC;
            VSYNC:   if (vs_rise) state_nxt = ACTIVE;
            ACTIVE:  if (vs_fall) state_nxt = VSYNC;
            default: state_nxt = SEEK;
        endcase
    end

    always_comb begin
        pix_valid   = 1'b0;
        frame_end   = 1'b0;
        frame_start = 1'b0;
        line_fix    = 1'b0;
        if (state == ACTIVE) begin
            pix_valid = iBLANK_n & iVS;
            frame_end = vs_fall;
            line_fix  = blank_fall & ~vs_fall & (col != '0);
        end
        if (state == VSYNC)
            frame_start = vs_rise;
    end

    assign wr_ok        = pix_valid & (addr < TOTAL);
    assign next_base    = row_base + H_STEP;
    assign realign_base = (next_base > TOTAL) ? TOTAL : next_base;
    assign frame_err_c  = line_err | overflow | (pix_cnt != TOTAL);

    // A short/long line snaps to the start of the following row.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            col      <= '0;
            row_base <= '0;
            addr     <= '0;
            pix_cnt  <= '0;
            line_err <= 1'b0;
            overflow <= 1'b0;
        end else if (frame_start) begin
            col      <= '0;
            row_base <= '0;
            addr     <= '0;
            pix_cnt  <= '0;
            line_err <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                pix_cnt <= pix_cnt + 1'b1;
                addr    <= addr + 1'b1;
                if (col == COL_LAST) begin
                    col      <= '0;
                    row_base <= next_base;
                end else begin
                    col <= col + 1'b1;
                end
            end else if (pix_valid) begin
                overflow <= 1'b1;
            end
            if (line_fix) begin
                line_err <= 1'b1;
                col      <= '0;
                row_base <= realign_base;
                addr     <= realign_base;
            end
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oWR_EN      <= 1'b0;
            oWR_ADDR    <= '0;
            oWR_DATA    <= '0;
            oFRAME_DONE <= 1'b0;
            oFRAME_PIX  <= '0;
            oFRAME_ERR  <= 1'b0;
            oLOCKED     <= 1'b0;
        end else begin
            oWR_EN      <= wr_ok;
            oFRAME_DONE <= frame_end;
            if (wr_ok) begin
                oWR_ADDR <= addr[ADDR_W-1:0];
                oWR_DATA <= {iR, iG, iB};
            end
            if (frame_end) begin
                oFRAME_PIX <= pix_cnt[ADDR_W-1:0];
                oFRAME_ERR <= frame_err_c;
                oLOCKED    <= ~frame_err_c;
            end
        end
    end

`ifdef VGA_CAPTURE_SUM_EN
    logic [31:0] sum;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sum        <= 32'd0;
            oFRAME_SUM <= 32'd0;
        end else begin
            if (frame_start)
                sum <= 32'd0;
            else if (wr_ok)
                sum <= sum + {8'd0, iR, iG, iB};
            if (frame_end)
                oFRAME_SUM <= sum;
        end
    end
`else
    assign oFRAME_SUM = 32'd0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 8x4 raster (12-cycle lines).
module tb_vga_capture;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int AW    = 6;
    localparam int TOTAL = H * V;
    localparam int HB    = 4;
    localparam int LINE  = H + HB;
    localparam logic [23:0] COLOR = 24'h102030;

    logic          vga_clk;
    logic          rst_n;
    logic          blank_n;
    logic          hs;
    logic          vs;
    logic [7:0]    r, g, b;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          frame_done;
    logic [AW-1:0] frame_pix;
    logic          frame_err;
    logic [31:0]   frame_sum;
    logic          locked;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int wb, db, wb2;
    logic [AW-1:0] log_addr [0:1023];
    logic [23:0]   mem      [0:63];

    vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .iVGA_CLK    (vga_clk),
        .iRST_n      (rst_n),
        .iBLANK_n    (blank_n),
        .iHS         (hs),
        .iVS         (vs),
        .iR          (r),
        .iG          (g),
        .iB          (b),
        .oWR_EN      (wr_en),
        .oWR_ADDR    (wr_addr),
        .oWR_DATA    (wr_data),
        .oFRAME_DONE (frame_done),
        .oFRAME_PIX  (frame_pix),
        .oFRAME_ERR  (frame_err),
        .oFRAME_SUM  (frame_sum),
        .oLOCKED     (locked)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Write/done recorder, sampled well clear of the clock edges.
    always @(posedge vga_clk) begin
        #2;
        if (wr_en) begin
            if (wr_cnt < 1024) log_addr[wr_cnt] = wr_addr;
            mem[wr_addr] = wr_data;
            wr_cnt++;
        end
        if (frame_done) done_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic bl, input logic v, input logic [23:0] rgb);
        blank_n = bl;
        vs      = v;
        hs      = bl;
        {r, g, b} = rgb;
        @(negedge vga_clk);
    endtask

    task automatic blankLines(input int n, input logic v);
        repeat (n * LINE) applyStimulus(1'b0, v, 24'd0);
    endtask

    task automatic sendLine(input int npix, input int start, input bit pat);
        logic [7:0] cv;
        for (int c = start; c < npix; c++) begin
            cv = 8'(c);
            applyStimulus(1'b1, 1'b1, pat ? {cv, cv, cv} : COLOR);
        end
        repeat (HB) applyStimulus(1'b0, 1'b1, 24'd0);
    endtask

    task automatic sendSync();
        blankLines(2, 1'b0);
        blankLines(1, 1'b1);
    endtask

    task automatic sendFrame(input int nlines, input int short_idx);
        for (int l = 0; l < nlines; l++)
            sendLine((l == short_idx) ? H - 1 : H, 0, 1'b0);
        blankLines(1, 1'b1);
        sendSync();
    endtask

    task automatic mark();
        wb = wr_cnt;
        db = done_cnt;
    endtask

    function automatic logic [31:0] sumExp(input int n);
`ifdef VGA_CAPTURE_SUM_EN
        return 32'(n) * {8'd0, COLOR};
`else
        return 32'(n - n);
`endif
    endfunction

    initial begin
        bit seq_ok;
        rst_n = 1'b0;
        blank_n = 1'b0; hs = 1'b1; vs = 1'b1; r = 8'd0; g = 8'd0; b = 8'd0;
        repeat (3) @(negedge vga_clk);

        checkOutput("rst_wr_en",   wr_en,      0);
        checkOutput("rst_wr_addr", wr_addr,    0);
        checkOutput("rst_wr_data", wr_data,    0);
        checkOutput("rst_done",    frame_done, 0);
        checkOutput("rst_pix",     frame_pix,  0);
        checkOutput("rst_err",     frame_err,  0);
        checkOutput("rst_sum",     frame_sum,  0);
        checkOutput("rst_locked",  locked,     0);
        rst_n = 1'b1;

        // Stimulus joins mid-frame: nothing captured until a full sync.
        mark();
        for (int l = 0; l < 3; l++) sendLine(H, 0, 1'b0);
        blankLines(1, 1'b1);
        checkOutput("seek_writes", wr_cnt - wb, 0);
        sendSync();
        checkOutput("seek_done",   done_cnt - db, 0);
        checkOutput("sync_writes", wr_cnt - wb, 0);

        mark();
        sendFrame(V, -1);
        checkOutput("f1_done",   done_cnt - db, 1);
        checkOutput("f1_writes", wr_cnt - wb, TOTAL);
        checkOutput("f1_first",  log_addr[wb], 0);
        checkOutput("f1_last",   log_addr[wb + TOTAL - 1], TOTAL - 1);
        seq_ok = 1'b1;
        for (int i = 0; i < TOTAL; i++)
            if (log_addr[wb + i] != AW'(i)) seq_ok = 1'b0;
        checkOutput("f1_seq",    seq_ok, 1);
        checkOutput("f1_pix",    frame_pix, TOTAL);
        checkOutput("f1_err",    frame_err, 0);
        checkOutput("f1_locked", locked, 1);
        checkOutput("f1_sum",    frame_sum, sumExp(TOTAL));

        // Line 2 one pixel short; line 3 must realign to row 3.
        mark();
        sendFrame(V, 2);
        checkOutput("short_writes", wr_cnt - wb, TOTAL - 1);
        checkOutput("short_lastpx", log_addr[wb + 22], 22);
        checkOutput("short_realgn", log_addr[wb + 23], 3 * H);
        checkOutput("short_pix",    frame_pix, TOTAL - 1);
        checkOutput("short_err",    frame_err, 1);
        checkOutput("short_locked", locked, 0);
        checkOutput("short_sum",    frame_sum, sumExp(TOTAL - 1));

        mark();
        sendFrame(V, -1);
        checkOutput("relock_locked", locked, 1);
        checkOutput("relock_err",    frame_err, 0);

        // One extra active line overflows the framebuffer.
        mark();
        sendFrame(V + 1, -1);
        checkOutput("ovf_writes", wr_cnt - wb, TOTAL);
        checkOutput("ovf_last",   log_addr[wb + TOTAL - 1], TOTAL - 1);
        checkOutput("ovf_pix",    frame_pix, TOTAL);
        checkOutput("ovf_err",    frame_err, 1);
        checkOutput("ovf_locked", locked, 0);

        // Reset in the middle of line 2.
        mark();
        sendLine(H, 0, 1'b0);
        sendLine(H, 0, 1'b0);
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b1, COLOR);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, COLOR);
        checkOutput("mrst_wr_en",  wr_en, 0);
        checkOutput("mrst_pix",    frame_pix, 0);
        checkOutput("mrst_err",    frame_err, 0);
        checkOutput("mrst_locked", locked, 0);
        checkOutput("mrst_done",   frame_done, 0);
        rst_n = 1'b1;
        wb2 = wr_cnt;
        for (int c = 4; c < H; c++) applyStimulus(1'b1, 1'b1, COLOR);
        repeat (HB) applyStimulus(1'b0, 1'b1, 24'd0);
        sendLine(H, 0, 1'b0);
        blankLines(1, 1'b1);
        sendSync();
        checkOutput("mrst_nodone",   done_cnt - db, 0);
        checkOutput("mrst_nowrites", wr_cnt - wb2, 0);
        mark();
        sendFrame(V, -1);
        checkOutput("resume_done",   done_cnt - db, 1);
        checkOutput("resume_pix",    frame_pix, TOTAL);
        checkOutput("resume_locked", locked, 1);

        // Column pattern frame, with the one-cycle write latency checked on pixel 0.
        mark();
        blank_n = 1'b1; vs = 1'b1; hs = 1'b1; {r, g, b} = 24'd0;
        checkOutput("lat_pre_en", wr_en, 0);
        @(negedge vga_clk);
        checkOutput("lat_en",   wr_en, 1);
        checkOutput("lat_addr", wr_addr, 0);
        checkOutput("lat_data", wr_data, 24'h000000);
        sendLine(H, 1, 1'b1);
        for (int l = 1; l < V; l++) sendLine(H, 0, 1'b1);
        blankLines(1, 1'b1);
        sendSync();
        checkOutput("pat_addr_h1", mem[H + 1], 24'h010101);
        checkOutput("pat_last",    mem[TOTAL - 1], 24'h070707);
        checkOutput("pat_row2_c3", mem[2 * H + 3], 24'h030303);
        checkOutput("pat_pix",     frame_pix, TOTAL);
        checkOutput("pat_locked",  locked, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
